// File: rtl/sevenseg_scan_ctrl.sv
// Time-multiplexed scan controller for a multi-digit 7-segment display sharing one decoder.
// New words are accepted through valid/ready and applied only at frame boundaries.
module sevenseg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int SLOT_CYCLES  = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      wr_valid,
  input  logic [4*NUM_DIGITS-1:0]   wr_data,
  output logic                      wr_ready,
  output logic [3:0]                bcd_out,
  output logic [NUM_DIGITS-1:0]     digit_en,
  output logic                      frame_done,
  output logic                      bad_digit
);

  // state | meaning
  // BLANK | slot guard time, all digit commons off
  // SHOW  | current digit driven (unless its code is invalid)
  typedef enum logic {BLANK, SHOW} state_t;

  localparam int CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int IW = $clog2(NUM_DIGITS);

  state_t                  state, state_nx;
  logic [CW-1:0]           cnt, cnt_nx;
  logic [IW-1:0]           idx, idx_nx;
  logic [4*NUM_DIGITS-1:0] display, disp_nx;
  logic [4*NUM_DIGITS-1:0] pend_word;
  logic                    pend, pend_nx;
  logic                    paused;
  logic                    slot_end, last_digit, wrap, xfer;
  logic [3:0]              code_nx;

  always_comb begin
    slot_end   = (cnt == CW'(SLOT_CYCLES - 1));
    last_digit = (idx == IW'(NUM_DIGITS - 1));
    wrap       = en && !paused && slot_end && last_digit;
    xfer       = wr_valid && wr_ready;
    disp_nx    = (wrap && pend) ? pend_word : display;
    cnt_nx     = cnt;
    idx_nx     = idx;
    if (en) begin
      if (paused) begin
        // resume at the start of the current digit's slot
        cnt_nx = '0;
      end else if (slot_end) begin
        cnt_nx = '0;
        idx_nx = last_digit ? '0 : idx + IW'(1);
      end else begin
        cnt_nx = cnt + CW'(1);
      end
    end
    state_nx = (cnt_nx >= CW'(BLANK_CYCLES)) ? SHOW : BLANK;
    code_nx  = disp_nx[{idx_nx, 2'b00} +: 4];
    pend_nx  = pend;
    if (wrap && pend) pend_nx = 1'b0;
    if (xfer)         pend_nx = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= BLANK;
      cnt        <= '0;
      idx        <= '0;
      display    <= '0;
      pend_word  <= '0;
      pend       <= 1'b0;
      paused     <= 1'b0;
      wr_ready   <= 1'b1;
      bcd_out    <= 4'd0;
      digit_en   <= '0;
      frame_done <= 1'b0;
      bad_digit  <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      idx        <= idx_nx;
      display    <= disp_nx;
      pend       <= pend_nx;
      wr_ready   <= !pend_nx;
      paused     <= !en;
      frame_done <= wrap;
      if (xfer) pend_word <= wr_data;
      // code is set on BLANK entry so it settles before the common line rises
      if (en && cnt_nx == '0) bcd_out <= code_nx;
      if (en && state_nx == SHOW && code_nx <= 4'd9)
        digit_en <= NUM_DIGITS'(1) << idx_nx;
      else
        digit_en <= '0;
      if (en && state_nx == SHOW && code_nx > 4'd9) bad_digit <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Randomized scoreboard bench for sevenseg_scan_ctrl with a frame-position reference model.
module tb_sevenseg_scan_ctrl;

  localparam int ND     = 4;
  localparam int SLOT   = 8;
  localparam int BLANK  = 2;
  localparam int FRAME  = ND * SLOT;
  localparam int N_CYC  = 4000;

  logic            clk = 1'b0;
  logic            rst, en, wr_valid;
  logic [4*ND-1:0] wr_data;
  logic            wr_ready, frame_done, bad_digit;
  logic [3:0]      bcd_out;
  logic [ND-1:0]   digit_en;

  sevenseg_scan_ctrl #(.NUM_DIGITS(ND), .SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLANK)) dut (
    .clk(clk), .rst(rst), .en(en), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .bcd_out(bcd_out), .digit_en(digit_en),
    .frame_done(frame_done), .bad_digit(bad_digit)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          rdy;
    logic [3:0]    bcd;
    logic [ND-1:0] den;
    logic          fd;
    logic          bad;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // reference model: position within a frame, digit = pos / SLOT, phase = pos % SLOT
  int              m_pos;
  bit              m_paused, m_pend, m_bad, m_fd;
  logic [4*ND-1:0] m_disp, m_pend_word;
  logic [3:0]      m_bcd;
  logic [ND-1:0]   m_den;

  function automatic logic [3:0] digit_of(logic [4*ND-1:0] w, int d);
    return w[4*d +: 4];
  endfunction

  function automatic logic [4*ND-1:0] rand_word();
    logic [4*ND-1:0] w;
    for (int k = 0; k < ND; k++)
      w[4*k +: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                                 : 4'($urandom_range(0, 9));
    return w;
  endfunction

  task automatic model_step();
    exp_t e;
    bit   xfer;
    int   phase, d;
    if (rst) begin
      m_pos = 0; m_paused = 0; m_pend = 0; m_bad = 0; m_fd = 0;
      m_disp = '0; m_pend_word = '0; m_bcd = 4'd0; m_den = '0;
    end else begin
      xfer = wr_valid && !m_pend;
      m_fd = 0;
      if (!en) begin
        m_paused = 1;
        m_den = '0;
      end else if (m_paused) begin
        m_paused = 0;
        m_pos = (m_pos / SLOT) * SLOT;
        m_bcd = digit_of(m_disp, m_pos / SLOT);
        m_den = '0;
      end else begin
        if (m_pos == FRAME - 1) begin
          m_fd = 1;
          if (m_pend) begin
            m_disp = m_pend_word;
            m_pend = 0;
          end
        end
        m_pos = (m_pos + 1) % FRAME;
        phase = m_pos % SLOT;
        d     = m_pos / SLOT;
        if (phase == 0) m_bcd = digit_of(m_disp, d);
        m_den = '0;
        if (phase >= BLANK) begin
          if (digit_of(m_disp, d) <= 9) m_den = ND'(1 << d);
          else m_bad = 1;
        end
      end
      if (xfer) begin
        m_pend = 1;
        m_pend_word = wr_data;
      end
    end
    e.rdy = !m_pend; e.bcd = m_bcd; e.den = m_den; e.fd = m_fd; e.bad = m_bad;
    exp_q.push_back(e);
  endtask

  task automatic drive_random(int cyc);
    if (cyc < 3) begin
      rst = 1; en = 0; wr_valid = 0; wr_data = '0;
      return;
    end
    rst = ($urandom_range(0, 799) == 0);
    if ($urandom_range(0, 59) == 0) en = ~en;
    if (cyc < 40) en = 1;
    wr_valid = ($urandom_range(0, 99) < 3) || (wr_valid && !wr_ready);
    if ($urandom_range(0, 3) == 0) wr_data = rand_word();
  endtask

  initial begin
    rst = 1; en = 0; wr_valid = 0; wr_data = '0;
    fork
      begin : driver
        for (int c = 0; c < N_CYC; c++) begin
          @(negedge clk);
          drive_random(c);
          model_step();
        end
      end
      begin : monitor
        exp_t e;
        @(negedge clk);
        for (int c = 0; c < N_CYC; c++) begin
          @(posedge clk);
          #1;
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL scoreboard_empty cycle %0d: no expected entry", c);
          end else begin
            e = exp_q.pop_front();
            if (wr_ready !== e.rdy || bcd_out !== e.bcd || digit_en !== e.den ||
                frame_done !== e.fd || bad_digit !== e.bad) begin
              miscompares++;
              $display("FAIL outputs cycle %0d: got rdy=%b bcd=%h den=%b fd=%b bad=%b, want rdy=%b bcd=%h den=%b fd=%b bad=%b",
                       c, wr_ready, bcd_out, digit_en, frame_done, bad_digit,
                       e.rdy, e.bcd, e.den, e.fd, e.bad);
            end
          end
        end
      end
    join
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
